// File: rtl/div_unit_pkg.sv
// Shared execute-stage definitions: ALU op/select codes, zero word and the
// divider FSM / handshake encodings.
package div_unit_pkg;

  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  localparam logic [7:0]  EXE_NOP_OP        = 8'b0000_0000;
  localparam logic [7:0]  EXE_ADD_OP        = 8'b0010_0000;
  localparam logic [7:0]  EXE_SUB_OP        = 8'b0010_0010;
  localparam logic [7:0]  EXE_MULT_OP       = 8'b0001_1000;
  localparam logic [7:0]  EXE_MULTU_OP      = 8'b0001_1001;
  localparam logic [7:0]  EXE_DIV_OP        = 8'b0001_1010;
  localparam logic [7:0]  EXE_DIVU_OP       = 8'b0001_1011;

  localparam logic [2:0]  EXE_RES_NOP       = 3'b000;
  localparam logic [2:0]  EXE_RES_LOGIC     = 3'b001;
  localparam logic [2:0]  EXE_RES_SHIFT     = 3'b010;
  localparam logic [2:0]  EXE_RES_MOVE      = 3'b011;
  localparam logic [2:0]  EXE_RES_ARITHMETIC = 3'b100;
  localparam logic [2:0]  EXE_RES_MUL       = 3'b101;

  localparam logic [1:0]  DivFree           = 2'b00;
  localparam logic [1:0]  DivByZero         = 2'b01;
  localparam logic [1:0]  DivOn             = 2'b10;
  localparam logic [1:0]  DivEnd            = 2'b11;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// MSB first, results {remainder, quotient} for HI/LO.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quot;
  logic              sign_a;
  logic              sign_b;
  logic              sgn;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  always_comb begin
    a_mag   = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    b_mag   = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    // Remainder stays below the divisor, so the shifted value fits DATA_W+1 bits
    shifted = {rem, dvd[DATA_W-1]};
    trial   = shifted - {1'b0, dvs};
    q_fix   = (sgn && (sign_a ^ sign_b)) ? (~quot + 1'b1) : quot;
    r_fix   = (sgn && sign_a) ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quot     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      sgn      <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            dvd    <= a_mag;
            dvs    <= b_mag;
            sgn    <= signed_div_i;
            sign_a <= opdata1_i[DATA_W-1];
            sign_b <= opdata2_i[DATA_W-1];
            rem    <= '0;
            quot   <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= (opdata2_i == '0) ? DivByZero : DivOn;
          end else begin
            busy_o <= 1'b0;
          end
        end

        DivByZero: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else begin
            state    <= DivEnd;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end

        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            busy_o   <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (cnt == CNT_W'(DATA_W)) begin
            state    <= DivEnd;
            busy_o   <= 1'b0;
            result_o <= {r_fix, q_fix};
            ready_o  <= DivResultReady;
          end else begin
            dvd <= {dvd[DATA_W-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (!trial[DATA_W]) begin
              rem  <= trial[DATA_W-1:0];
              quot <= {quot[DATA_W-2:0], 1'b1};
            end else begin
              rem  <= shifted[DATA_W-1:0];
              quot <= {quot[DATA_W-2:0], 1'b0};
            end
          end
        end

        default: begin  // DivEnd
          busy_o <= 1'b0;
          if (start_i == DivStop || annul_i) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, sign handling,
// divide-by-zero, annul and reset behaviour.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, ".ready"},  64'(ready_o),  64'd0);
    check_val({tag, ".busy"},   64'(busy_o),   64'd0);
    check_val({tag, ".result"}, result_o,      64'd0);
  endtask

  // Starts an operation, scrambles operands after E0, waits for ready,
  // checks latency/busy/result, then checks hold and release.
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int unsigned exp_edges, input int unsigned exp_busy);
    int unsigned edges = 0;
    int unsigned busy_n = 0;
    bit done = 0;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      edges++;
      if (i == 0) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sd;
      end
      if (ready_o) done = 1;
      else if (busy_o) busy_n++;
    end
    check_val({tag, ".done"},   64'(done),   64'd1);
    check_val({tag, ".edges"},  64'(edges),  64'(exp_edges));
    check_val({tag, ".busy_n"}, 64'(busy_n), 64'(exp_busy));
    check_val({tag, ".result"}, result_o,    exp);
    check_val({tag, ".busy_end"}, 64'(busy_o), 64'd0);
    tick();
    check_val({tag, ".hold_rdy"}, 64'(ready_o), 64'd1);
    check_val({tag, ".hold_res"}, result_o,     exp);
    start_i = 1'b0;
    tick();
    check_idle({tag, ".rel"});
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst     = 1'b0;
    start_i = 1'b0;
    tick();
    check_idle("idle");

    run_op("u100_7",  1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 34, 33);
    run_op("s-7_2",   1'b1, 32'hFFFFFFF9,  32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, 33);
    run_op("u-7_2",   1'b0, 32'hFFFFFFF9,  32'h00000002, 64'h00000001_7FFFFFFC, 34, 33);
    run_op("s7_-2",   1'b1, 32'h00000007,  32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 33);
    run_op("byzero",  1'b0, 32'h00001234,  32'h00000000, 64'h0, 2, 1);
    run_op("s_min_m1",1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 34, 33);

    // annul with start in FREE must not launch
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd1;
    tick();
    check_idle("annul_free");
    start_i = 1'b0; annul_i = 1'b0;
    tick();

    // annul during iteration 10
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    tick();
    check_val("annul.busy_e0", 64'(busy_o), 64'd1);
    for (int i = 0; i < 9; i++) tick();
    annul_i = 1'b1;
    tick();
    check_idle("annul_on");
    annul_i = 1'b0; start_i = 1'b0;
    tick();
    check_idle("annul_gap1");
    tick();
    check_idle("annul_gap2");
    run_op("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 33);

    // reset at iteration 20, start held high through it
    signed_div_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    check_val("rst.busy_pre", 64'(busy_o), 64'd1);
    rst = 1'b1;
    tick();
    check_idle("rst_mid");
    rst = 1'b0; start_i = 1'b0;
    tick();
    check_idle("rst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
